stream_case_conv: RTL and testbench
===================================

# stream_case_conv

Pipelined, parametrised successor to the combinational 8-bit ASCII upper-case converter. Processes a stream of LANES bytes per beat over a valid/ready handshake, with a runtime-selectable case mode per beat. Keeps full throughput under back-pressure through a 2-entry output skid buffer, and keeps a saturating count of bytes actually changed. Sits between a byte-stream source (UART/FIFO) and the downstream text sink.

## Interface
- LANES, 4: bytes per beat; legal 1..16.
- COUNT_W, 16: width of the converted-byte counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  case mode, sampled on the accepting edge: 00 pass, 01 to-upper, 10 to-lower, 11 toggle.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  8*LANES  input bytes; lane k = bits [8k+7:8k].
- s_keep  in  LANES  per-lane byte-valid.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  8*LANES  converted bytes.
- m_keep  out  LANES  s_keep carried with its beat.
- count_clr  in  1  synchronous clear of conv_count.
- conv_count  out  COUNT_W  saturating count of changed bytes.

## Operation
- Accept when s_valid && s_ready. Output transfer when m_valid && m_ready.
- Per lane, with keep=1, byte b:
  - Upper letter: 0x41..0x5A. Lower letter: 0x61..0x7A.
  - to-upper: lower letters get bit5 cleared.
  - to-lower: upper letters get bit5 set.
  - toggle: any letter gets bit5 inverted.
  - pass, non-letters, and bytes >= 0x80: unchanged.
- Lanes with keep=0: byte passes unchanged, is never counted, and m_keep bit = 0.
- A lane is "changed" when its output byte differs from its input byte.
- Buffer: output register OR plus skid register SK. Control state:
  - EMPTY: OR and SK invalid; s_ready=1. Accept -> ONE.
  - ONE: OR valid; s_ready=1.
    - Accept with no output transfer -> TWO (new beat goes to SK).
    - Accept with output transfer -> ONE (new beat goes to OR).
    - Output transfer only -> EMPTY.
  - TWO: OR and SK valid; s_ready=0. Output transfer -> ONE (SK moves to OR, SK cleared).
- Beat order is strictly preserved. No beat is dropped or duplicated.
- conv_count, on each accept:
  - Add the number of changed lanes in the accepted beat.
  - Saturate at 2^COUNT_W-1.
  - count_clr alone sets it to 0.
  - count_clr together with an accept sets it to that beat's changed-lane count.
- mode changes take effect on the next accepted beat. Beats already buffered keep the mode they were accepted with.

## Timing
- Reset, while rst=1 and on the first edge with rst=1:
  - State EMPTY.
  - m_valid=0, m_data=0, m_keep=0.
  - s_ready=0 while rst is high; s_ready=1 from the first cycle after rst falls.
  - conv_count=0.
  - Buffered beats are discarded.
- Reset mid-stream: same as above. No partial output. Count cleared regardless of count_clr.
- Latency: a beat accepted at edge N appears on m_data/m_valid after edge N, when OR was empty or is draining that same cycle.
- Throughput: 1 beat/clock while m_ready=1.
- s_ready is a registered output (a function of state only). It never depends combinationally on m_ready.
- While m_valid=1 and m_ready=0, m_data and m_keep are held stable.
- m_valid never deasserts without a transfer.
- conv_count updates on the accepting edge, so the new value is visible in the cycle after the accept.

## Test plan
- Beat, LANES=4, mode=01, s_data=0x61_5A_7A_28, keep=1111, m_ready=1 -> m_data=0x41_5A_5A_28 one cycle later; conv_count=2.
- mode=11 on 0x6D_47_30_CF, keep=1111 -> 0x4D_67_30_CF; count +2. mode=10 on 0x41_7B_40_5B -> 0x61_7B_40_5B (boundary bytes 0x40/0x5B/0x7B unchanged); count +1.
- keep=0101 on 0x61_61_61_61, mode=01 -> m_data=0x61_41_61_41, m_keep=0101; count +2.
- Stream 8 beats with m_ready held low for 3 cycles:
  - s_ready drops after 2 accepts.
  - Outputs emerge in order with no loss.
  - m_data is stable while stalled.
  - Full rate resumes once m_ready returns high.
- COUNT_W=4: drive 5 beats of 4 lower letters with mode=01 -> conv_count saturates at 15. count_clr asserted together with one more accept -> conv_count=4.
- Assert rst for one cycle with 2 beats buffered:
  - m_valid=0, conv_count=0, s_ready=0 during reset.
  - s_ready=1 the next cycle.
  - Buffered beats never appear.

Source files
------------

// File: rtl/stream_case_conv.sv
// stream_case_conv
//   Converts the letter case of a byte stream, LANES bytes per beat, over a
//   valid/ready handshake. The case mode is captured with each beat. A
//   two-entry output buffer (output register + skid register) sustains one
//   beat per clock while keeping s_ready a registered signal. A saturating
//   counter tracks how many bytes were actually changed.
//
//   clk, rst          rising-edge clock, synchronous active-high reset
//   mode              00 pass, 01 to-upper, 10 to-lower, 11 toggle
//   s_valid/s_ready   input handshake; s_data lane k = [8k+7:8k], s_keep
//   m_valid/m_ready   output handshake; m_data, m_keep
//   count_clr         clears conv_count (an accept in the same cycle wins
//                     with that beat's changed-lane count)
//   conv_count        saturating count of changed bytes

// Single-lane converter: a letter changes case by flipping bit 5.
module stream_case_conv_lane (
  input  logic [7:0] b,
  input  logic       keep,
  input  logic [1:0] mode,
  output logic [7:0] o,
  output logic       changed
);
  logic up, lo, flip;

  assign up = (b >= 8'h41) && (b <= 8'h5A);
  assign lo = (b >= 8'h61) && (b <= 8'h7A);

  always_comb begin
    flip = 1'b0;
    if (keep) begin
      case (mode)
        2'b01:   flip = lo;
        2'b10:   flip = up;
        2'b11:   flip = up | lo;
        default: flip = 1'b0;
      endcase
    end
  end

  assign o       = b ^ {2'b00, flip, 5'b00000};
  assign changed = flip;
endmodule

module stream_case_conv #(
  parameter int LANES   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [8*LANES-1:0]   s_data,
  input  logic [LANES-1:0]     s_keep,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [8*LANES-1:0]   m_data,
  output logic [LANES-1:0]     m_keep,
  input  logic                 count_clr,
  output logic [COUNT_W-1:0]   conv_count
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // Sum width leaves headroom for up to 16 changed lanes on top of the count.
  localparam int SW = COUNT_W + 5;
  localparam logic [SW-1:0] CMAX = {5'b00000, {COUNT_W{1'b1}}};

  state_t               state, state_nxt;
  logic [8*LANES-1:0]   cdat, sk_data;
  logic [LANES-1:0]     chg, sk_keep;
  logic                 rdy_q, accept, xfer;
  logic                 ld_or_in, ld_or_sk, ld_sk;
  logic [4:0]           nchg;
  logic [SW-1:0]        cnt_base, cnt_sum;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    stream_case_conv_lane u_lane (
      .b       (s_data[8*gi +: 8]),
      .keep    (s_keep[gi]),
      .mode    (mode),
      .o       (cdat[8*gi +: 8]),
      .changed (chg[gi])
    );
  end

  // rdy_q is the registered "not full" flag; rst only masks it so nothing is
  // offered while reset is held.
  assign s_ready = rdy_q & ~rst;
  assign m_valid = (state != EMPTY);
  assign accept  = s_valid & s_ready;
  assign xfer    = m_valid & m_ready;

  always_comb begin
    state_nxt = state;
    ld_or_in  = 1'b0;
    ld_or_sk  = 1'b0;
    ld_sk     = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        ld_or_in  = 1'b1;
      end
      ONE: begin
        if (accept && !xfer) begin
          state_nxt = TWO;
          ld_sk     = 1'b1;
        end else if (accept && xfer) begin
          ld_or_in  = 1'b1;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (xfer) begin
        state_nxt = ONE;
        ld_or_sk  = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    nchg = '0;
    for (int i = 0; i < LANES; i++) nchg = nchg + 5'(chg[i]);
  end

  assign cnt_base = count_clr ? '0 : {5'b00000, conv_count};
  assign cnt_sum  = cnt_base + {{(SW-5){1'b0}}, nchg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rdy_q      <= 1'b1;
      m_data     <= '0;
      m_keep     <= '0;
      sk_data    <= '0;
      sk_keep    <= '0;
      conv_count <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != TWO);
      if (ld_or_in) begin
        m_data <= cdat;
        m_keep <= s_keep;
      end else if (ld_or_sk) begin
        m_data <= sk_data;
        m_keep <= sk_keep;
      end
      if (ld_sk) begin
        sk_data <= cdat;
        sk_keep <= s_keep;
      end else if (ld_or_sk) begin
        sk_data <= '0;
        sk_keep <= '0;
      end
      if (accept)
        conv_count <= (cnt_sum > CMAX) ? {COUNT_W{1'b1}} : cnt_sum[COUNT_W-1:0];
      else if (count_clr)
        conv_count <= '0;
    end
  end
endmodule

// File: tb/tb_stream_case_conv.sv
module tb_stream_case_conv;
  logic        clk = 1'b0;
  logic        rst, s_valid, m_ready, count_clr;
  logic [1:0]  mode;
  logic [31:0] s_data;
  logic [3:0]  s_keep;

  logic        s_ready, m_valid, s_ready4, m_valid4;
  logic [31:0] m_data, m_data4;
  logic [3:0]  m_keep, m_keep4;
  logic [15:0] conv_count;
  logic [3:0]  conv_count4;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] d; logic [3:0] k; } beat_t;
  beat_t q[$];
  int    cnt16, cnt4, acc_total;
  bit    in_rst;

  always #5 clk = ~clk;

  stream_case_conv #(.LANES(4), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_keep(s_keep), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .count_clr(count_clr), .conv_count(conv_count));

  stream_case_conv #(.LANES(4), .COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .s_keep(s_keep), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .m_keep(m_keep4), .count_clr(count_clr), .conv_count(conv_count4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from the case rules, in plain integer arithmetic.
  function automatic int conv_byte(input int b, input int md);
    bit up, lo;
    up = (b >= 65) && (b <= 90);
    lo = (b >= 97) && (b <= 122);
    case (md)
      1: return lo ? b - 32 : b;
      2: return up ? b + 32 : b;
      3: return up ? b + 32 : (lo ? b - 32 : b);
      default: return b;
    endcase
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 5))
      0: return 8'($urandom_range(8'h41, 8'h5A));
      1: return 8'($urandom_range(8'h61, 8'h7A));
      2: return 8'h40;
      3: return 8'h5B;
      4: return ($urandom_range(0, 1) != 0) ? 8'h60 : 8'h7B;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic compare();
    bit ev;
    ev = (q.size() > 0);
    chk("s_ready",  {31'd0, s_ready},  {31'd0, !in_rst && q.size() < 2});
    chk("s_ready4", {31'd0, s_ready4}, {31'd0, !in_rst && q.size() < 2});
    chk("m_valid",  {31'd0, m_valid},  {31'd0, ev});
    chk("m_valid4", {31'd0, m_valid4}, {31'd0, ev});
    if (ev) begin
      chk("m_data",  m_data,           q[0].d);
      chk("m_keep",  {28'd0, m_keep},  {28'd0, q[0].k});
      chk("m_data4", m_data4,          q[0].d);
    end else if (in_rst) begin
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_m_keep", {28'd0, m_keep}, 32'd0);
    end
    chk("conv_count",  {16'd0, conv_count},  cnt16);
    chk("conv_count4", {28'd0, conv_count4}, cnt4);
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input bit r, input bit sv, input logic [1:0] md,
                      input logic [31:0] d, input logic [3:0] k,
                      input bit mr, input bit clr);
    beat_t b;
    int    n, ib, ob;
    bit    acc, xf;
    rst = r; s_valid = sv; mode = md; s_data = d; s_keep = k;
    m_ready = mr; count_clr = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      acc = sv && (q.size() < 2);
      xf  = mr && (q.size() > 0);
      n = 0;
      b.k = k;
      for (int i = 0; i < 4; i++) begin
        ib = int'(d[8*i +: 8]);
        ob = k[i] ? conv_byte(ib, int'(md)) : ib;
        if (ob != ib) n++;
        b.d[8*i +: 8] = 8'(ob);
      end
      if (xf) void'(q.pop_front());
      if (acc) begin
        q.push_back(b);
        acc_total++;
        cnt16 = (clr ? 0 : cnt16) + n;
        cnt4  = (clr ? 0 : cnt4) + n;
        if (cnt16 > 65535) cnt16 = 65535;
        if (cnt4 > 15) cnt4 = 15;
      end else if (clr) begin
        cnt16 = 0;
        cnt4  = 0;
      end
    end
    in_rst = r;
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input bit mr);
    step(0, 0, 2'b00, 32'd0, 4'h0, mr, 0);
  endtask

  initial begin
    int start;
    acc_total = 0;
    step(1, 0, 2'b00, 32'd0, 4'h0, 0, 0);
    step(1, 1, 2'b01, 32'h61616161, 4'hF, 1, 0);

    // Hand-computed beats that pin the model.
    step(0, 1, 2'b01, 32'h615A7A28, 4'hF, 1, 0);
    chk("lit_upper", m_data, 32'h415A5A28);
    chk("lit_cnt1", {16'd0, conv_count}, 32'd2);
    step(0, 1, 2'b11, 32'h6D4730CF, 4'hF, 1, 0);
    chk("lit_toggle", m_data, 32'h4D6730CF);
    chk("lit_cnt2", {16'd0, conv_count}, 32'd4);
    step(0, 1, 2'b10, 32'h417B405B, 4'hF, 1, 0);
    chk("lit_lower", m_data, 32'h617B405B);
    chk("lit_cnt3", {16'd0, conv_count}, 32'd5);
    step(0, 1, 2'b01, 32'h61616161, 4'b0101, 1, 0);
    chk("lit_keep_data", m_data, 32'h61416141);
    chk("lit_keep", {28'd0, m_keep}, 32'h5);
    chk("lit_cnt4", {16'd0, conv_count}, 32'd7);
    idle(1);

    // 8 beats, downstream stalled for 3 cycles at the start.
    start = acc_total;
    step(0, 1, 2'b01, {rand_byte(), rand_byte(), rand_byte(), rand_byte()}, 4'hF, 0, 0);
    step(0, 1, 2'b11, {rand_byte(), rand_byte(), rand_byte(), rand_byte()}, 4'hF, 0, 0);
    chk("stall_sready_low", {31'd0, s_ready}, 32'd0);
    step(0, 1, 2'b10, {rand_byte(), rand_byte(), rand_byte(), rand_byte()}, 4'hF, 0, 0);
    for (int c = 0; c < 40 && acc_total - start < 8; c++)
      step(0, 1, 2'($urandom), {rand_byte(), rand_byte(), rand_byte(), rand_byte()}, 4'hF, 1, 0);
    chk("stall_accepted", acc_total - start, 8);
    for (int c = 0; c < 4; c++) idle(1);
    chk("stall_drained", {31'd0, m_valid}, 32'd0);

    // Saturation of the narrow counter, then clear together with an accept.
    step(1, 0, 2'b00, 32'd0, 4'h0, 1, 0);
    for (int c = 0; c < 5; c++) step(0, 1, 2'b01, 32'h61626364, 4'hF, 1, 0);
    chk("sat_cnt4", {28'd0, conv_count4}, 32'd15);
    chk("sat_cnt16", {16'd0, conv_count}, 32'd20);
    step(0, 1, 2'b01, 32'h61626364, 4'hF, 1, 1);
    chk("clr_acc_cnt4", {28'd0, conv_count4}, 32'd4);
    chk("clr_acc_cnt16", {16'd0, conv_count}, 32'd4);
    step(0, 0, 2'b00, 32'd0, 4'h0, 1, 1);
    chk("clr_only", {16'd0, conv_count}, 32'd0);

    // Random traffic with occasional resets and clears.
    for (int c = 0; c < 2000; c++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 2'($urandom),
           {rand_byte(), rand_byte(), rand_byte(), rand_byte()}, 4'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);

    // Reset with two beats buffered.
    idle(1);
    idle(1);
    step(0, 1, 2'b01, 32'h61616161, 4'hF, 0, 0);
    step(0, 1, 2'b01, 32'h62626262, 4'hF, 0, 0);
    chk("pre_rst_full", {31'd0, s_ready}, 32'd0);
    step(1, 1, 2'b01, 32'h63636363, 4'hF, 0, 0);
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_sready", {31'd0, s_ready}, 32'd0);
    chk("rst_cnt", {16'd0, conv_count}, 32'd0);
    idle(0);
    chk("post_rst_sready", {31'd0, s_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      idle(1);
      chk("post_rst_no_beat", {31'd0, m_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
